// File: rtl/uart_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_initiator
// Brief    : APB3 initiator for a CoreUARTapb slave. It programs the baud and
//            frame config, then polls STATUS and bridges tx/rx byte streams.
//            Optional macro UART_INIT_ERR_FLAGS_EN adds sticky err_flags/err_clr.
// Revision : 1.0 - initial release
// ============================================================================
module uart_apb_initiator #(
    parameter logic [12:0] BAUD_VAL   = 13'd1,
    parameter logic        CFG_BIT8   = 1'b1,
    parameter logic        CFG_PARITY = 1'b0,
    parameter logic        CFG_ODD    = 1'b0,
    parameter int unsigned POLL_GAP   = 4
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       cfg_done,
    output logic       slverr
`ifdef UART_INIT_ERR_FLAGS_EN
    ,
    output logic [2:0] err_flags,
    input  logic       err_clr
`endif
);

    localparam logic [4:0] c_addr_txdata = 5'h00;
    localparam logic [4:0] c_addr_rxdata = 5'h04;
    localparam logic [4:0] c_addr_ctrl1  = 5'h08;
    localparam logic [4:0] c_addr_ctrl2  = 5'h0C;
    localparam logic [4:0] c_addr_status = 5'h10;
    localparam logic [7:0] c_gap_load    = 8'(POLL_GAP - 1);

    typedef enum logic [2:0] {
        S_CFG1 = 3'd0,
        S_CFG2 = 3'd1,
        S_POLL = 3'd2,
        S_RXRD = 3'd3,
        S_TXWR = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    state_t     state_q, state_d, next_state;
    logic       start_xfer;
    logic       psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [4:0] paddr_q, paddr_d;
    logic [7:0] pwdata_q, pwdata_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       cfg_done_q, cfg_done_d;
    logic       tx_ready_q, tx_ready_d;
    logic       slverr_q, slverr_d;
`ifdef UART_INIT_ERR_FLAGS_EN
    logic [2:0] err_flags_q, err_flags_d;
`endif

    always_comb begin
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        gap_cnt_d  = gap_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        cfg_done_d = cfg_done_q;
        tx_ready_d = 1'b0;
        slverr_d   = 1'b0;
        next_state = state_q;
        start_xfer = 1'b0;
`ifdef UART_INIT_ERR_FLAGS_EN
        err_flags_d = err_clr ? 3'b000 : err_flags_q;
`endif

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (!psel_q) begin
            // Idle bus: either just out of reset or counting down the poll gap.
            if (state_q != S_GAP) begin
                start_xfer = 1'b1;
            end else if (gap_cnt_q == 8'd0) begin
                next_state = S_POLL;
                start_xfer = 1'b1;
            end else begin
                gap_cnt_d = gap_cnt_q - 8'd1;
            end
        end else if (!penable_q) begin
            penable_d = 1'b1;
        end else if (PREADY) begin
            slverr_d = PSLVERR;
            case (state_q)
                S_CFG1: next_state = PSLVERR ? S_CFG1 : S_CFG2;
                S_CFG2: begin
                    if (PSLVERR) begin
                        next_state = S_CFG2;
                    end else begin
                        next_state = S_POLL;
                        cfg_done_d = 1'b1;
                    end
                end
                S_POLL: begin
                    if (PSLVERR) begin
                        next_state = S_GAP;
                    end else begin
`ifdef UART_INIT_ERR_FLAGS_EN
                        err_flags_d = err_flags_d | PRDATA[4:2];
`endif
                        if (PRDATA[1] && !rx_valid_q) begin
                            next_state = S_RXRD;
                        end else if (PRDATA[0] && tx_valid) begin
                            next_state = S_TXWR;
                        end else begin
                            next_state = S_GAP;
                        end
                    end
                end
                S_RXRD: begin
                    next_state = S_POLL;
                    if (!PSLVERR) begin
                        rx_data_d  = PRDATA;
                        rx_valid_d = 1'b1;
                    end
                end
                S_TXWR: begin
                    next_state = S_POLL;
                    tx_ready_d = !PSLVERR;
                end
                default: next_state = S_POLL;
            endcase

            if (next_state == S_GAP && POLL_GAP == 0) begin
                next_state = S_POLL;
                start_xfer = 1'b1;
            end else if (next_state == S_GAP) begin
                gap_cnt_d = c_gap_load;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
            end else begin
                start_xfer = 1'b1;
            end
        end

        state_d = next_state;

        if (start_xfer) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            case (next_state)
                S_CFG1: begin
                    paddr_d  = c_addr_ctrl1;
                    pwrite_d = 1'b1;
                    pwdata_d = BAUD_VAL[7:0];
                end
                S_CFG2: begin
                    paddr_d  = c_addr_ctrl2;
                    pwrite_d = 1'b1;
                    pwdata_d = {BAUD_VAL[12:8], CFG_ODD, CFG_PARITY, CFG_BIT8};
                end
                S_POLL: begin
                    paddr_d  = c_addr_status;
                    pwrite_d = 1'b0;
                end
                S_RXRD: begin
                    paddr_d  = c_addr_rxdata;
                    pwrite_d = 1'b0;
                end
                S_TXWR: begin
                    paddr_d  = c_addr_txdata;
                    pwrite_d = 1'b1;
                    pwdata_d = tx_data;
                end
                default: begin
                    psel_d   = 1'b0;
                    pwrite_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q    <= S_CFG1;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= 5'd0;
            pwdata_q   <= 8'd0;
            gap_cnt_q  <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            cfg_done_q <= 1'b0;
            tx_ready_q <= 1'b0;
            slverr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            gap_cnt_q  <= gap_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cfg_done_q <= cfg_done_d;
            tx_ready_q <= tx_ready_d;
            slverr_q   <= slverr_d;
        end
    end

`ifdef UART_INIT_ERR_FLAGS_EN
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            err_flags_q <= 3'b000;
        end else begin
            err_flags_q <= err_flags_d;
        end
    end
    assign err_flags = err_flags_q;
`endif

    assign PSEL     = psel_q;
    assign PENABLE  = penable_q;
    assign PWRITE   = pwrite_q;
    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign cfg_done = cfg_done_q;
    assign tx_ready = tx_ready_q;
    assign slverr   = slverr_q;

endmodule
`default_nettype wire
